// File: rtl/control_pkg.sv
// Shared control-unit constants: microstep geometry and named T-states.
package control_pkg;

  localparam int unsigned STEP_W      = 3;
  localparam int unsigned NUM_STEPS   = 5;
  localparam int unsigned FETCH_STEPS = 2;
  localparam int unsigned CNT_W       = 8;

  // Named microsteps for the control ROM (T0 = MAR<-PC, T1 = IR<-RAM, PC++).
  typedef enum logic [STEP_W-1:0] {
    T0 = 3'd0,
    T1 = 3'd1,
    T2 = 3'd2,
    T3 = 3'd3,
    T4 = 3'd4
  } step_e;

  // True for the final legal step and any out-of-range value, so both wrap to T0.
  function automatic logic is_wrap_step(input logic [STEP_W-1:0] s);
    return s >= STEP_W'(NUM_STEPS - 1);
  endfunction

endpackage

// File: rtl/microstep_counter_if.sv
// Sequencer control inputs and microstep/retire status outputs.
interface microstep_counter_if;
  import control_pkg::*;

  logic                 step_en;
  logic                 hlt;
  logic                 step_clr;
  logic [STEP_W-1:0]    step;
  logic [NUM_STEPS-1:0] t_onehot;
  logic                 fetch;
  logic                 instr_done;
  logic [CNT_W-1:0]     instr_cnt;

  // Clock module / control word side.
  modport master (
    output step_en, hlt, step_clr,
    input  step, t_onehot, fetch, instr_done, instr_cnt
  );

  // Sequencer side.
  modport slave (
    input  step_en, hlt, step_clr,
    output step, t_onehot, fetch, instr_done, instr_cnt
  );

endinterface

// File: rtl/step_decoder.sv
// Combinational decode of a binary microstep into one-hot and fetch flag.
module step_decoder
  import control_pkg::*;
(
  input  logic [STEP_W-1:0]    step,
  output logic [NUM_STEPS-1:0] t_onehot,
  output logic                 fetch
);

  // One-hot decode; out-of-range steps give all zeros.
  always_comb begin
    t_onehot = '0;
    for (int i = 0; i < NUM_STEPS; i++) begin
      t_onehot[i] = (step == STEP_W'(i));
    end
  end

  // Fetch covers the leading FETCH_STEPS microsteps.
  assign fetch = (step < STEP_W'(FETCH_STEPS));

endmodule

// File: rtl/microstep_counter.sv
// T-state sequencer: holds the current microstep, wraps/clears at end of
// instruction and counts retired instructions for the debug display.
module microstep_counter
  import control_pkg::*;
(
  input  logic                clk,
  input  logic                RESET,
  microstep_counter_if.slave  bus
);

  logic [STEP_W-1:0]    step_q, step_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 done_q, done_d;
  logic [NUM_STEPS-1:0] t_onehot;
  logic                 fetch;

  // Next-state: halt and disable both hold; clear or last step retires.
  always_comb begin
    step_d = step_q;
    cnt_d  = cnt_q;
    done_d = 1'b0;
    if (!bus.hlt && bus.step_en) begin
      if (bus.step_clr || is_wrap_step(step_q)) begin
        step_d = STEP_W'(T0);
        cnt_d  = cnt_q + CNT_W'(1);
        done_d = 1'b1;
      end else begin
        step_d = step_q + STEP_W'(1);
      end
    end
  end

  // State registers; reset abandons the in-flight instruction uncounted.
  always_ff @(posedge clk) begin
    if (RESET) begin
      step_q <= STEP_W'(T0);
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      step_q <= step_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  step_decoder u_step_decoder (
    .step     (step_q),
    .t_onehot (t_onehot),
    .fetch    (fetch)
  );

  assign bus.step       = step_q;
  assign bus.t_onehot   = t_onehot;
  assign bus.fetch      = fetch;
  assign bus.instr_done = done_q;
  assign bus.instr_cnt  = cnt_q;

endmodule
